// File: rtl/pipeline_mem_access_if.sv
// Memory-side bus of the MEM stage: a single outstanding request, held stable until acknowledged.
interface pipeline_mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/pipeline_mem_access.sv
// MEM pipeline stage: passes ALU results through, runs loads/stores over a req/ack bus,
// traps misaligned accesses and aborts requests that wait longer than MAX_WAIT cycles.
module pipeline_mem_access #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_E,
  input  logic        regWrite_E,
  input  logic        memWrite_E,
  input  logic        memRead2_E,
  input  logic [1:0]  rf_wr_sel_E,
  input  logic [4:0]  rd_E,
  input  logic [1:0]  size_E,
  input  logic        unsigned_E,
  input  logic [31:0] alu_result_E,
  input  logic [31:0] rs2_E,
  input  logic [31:0] PC_instr_E,
  pipeline_mem_access_if.master mem,
  output logic        valid_M,
  output logic        regWrite_M,
  output logic [1:0]  rf_wr_sel_M,
  output logic [4:0]  rd_M,
  output logic [31:0] alu_result_M,
  output logic [31:0] load_data_M,
  output logic [31:0] PC_instr_M,
  output logic        misalign_M,
  output logic        timeout_M,
  output logic        stall_M
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e      state_q;
  logic [7:0]  waitCnt_q;

  logic        memWe_q;
  logic [31:0] memAddr_q;
  logic [31:0] memWdata_q;
  logic [3:0]  memBe_q;

  logic        captRegWrite_q;
  logic [1:0]  captSel_q;
  logic [4:0]  captRd_q;
  logic [31:0] captAlu_q;
  logic [31:0] captPc_q;
  logic [1:0]  captSize_q;
  logic        captUnsigned_q;

  logic        validM_q;
  logic        regWriteM_q;
  logic [1:0]  selM_q;
  logic [4:0]  rdM_q;
  logic [31:0] aluM_q;
  logic [31:0] loadM_q;
  logic [31:0] pcM_q;
  logic        misalignM_q;
  logic        timeoutM_q;

  logic        isMemOp;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] laneData;
  logic [31:0] loadData_d;

  // Byte-enable and lane replication for the access being offered by execute.
  always_comb begin
    isMemOp    = memRead2_E | memWrite_E;
    misaligned = 1'b0;
    be_d       = 4'b0000;
    wdata_d    = 32'h0;
    case (size_E)
      2'b00: begin
        be_d    = 4'b0001 << alu_result_E[1:0];
        wdata_d = {4{rs2_E[7:0]}};
      end
      2'b01: begin
        misaligned = alu_result_E[0];
        be_d       = 4'b0011 << alu_result_E[1:0];
        wdata_d    = {2{rs2_E[15:0]}};
      end
      2'b10: begin
        misaligned = |alu_result_E[1:0];
        be_d       = 4'b1111;
        wdata_d    = rs2_E;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Read data arrives word-aligned; move the addressed lane down to bit 0 and extend it.
  always_comb begin
    laneData   = mem.mem_rdata >> {captAlu_q[1:0], 3'b000};
    loadData_d = 32'h0;
    if (!memWe_q) begin
      case (captSize_q)
        2'b00:   loadData_d = {{24{laneData[7] & ~captUnsigned_q}}, laneData[7:0]};
        2'b01:   loadData_d = {{16{laneData[15] & ~captUnsigned_q}}, laneData[15:0]};
        default: loadData_d = laneData;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      waitCnt_q      <= 8'd0;
      memWe_q        <= 1'b0;
      memAddr_q      <= 32'h0;
      memWdata_q     <= 32'h0;
      memBe_q        <= 4'b0000;
      captRegWrite_q <= 1'b0;
      captSel_q      <= 2'b00;
      captRd_q       <= 5'd0;
      captAlu_q      <= 32'h0;
      captPc_q       <= 32'h0;
      captSize_q     <= 2'b00;
      captUnsigned_q <= 1'b0;
      validM_q       <= 1'b0;
      regWriteM_q    <= 1'b0;
      selM_q         <= 2'b00;
      rdM_q          <= 5'd0;
      aluM_q         <= 32'h0;
      loadM_q        <= 32'h0;
      pcM_q          <= 32'h0;
      misalignM_q    <= 1'b0;
      timeoutM_q     <= 1'b0;
    end else begin
      validM_q    <= 1'b0;
      misalignM_q <= 1'b0;
      timeoutM_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_E) begin
            if (!isMemOp || misaligned) begin
              validM_q    <= 1'b1;
              misalignM_q <= isMemOp;
              regWriteM_q <= regWrite_E & ~isMemOp;
              selM_q      <= rf_wr_sel_E;
              rdM_q       <= rd_E;
              aluM_q      <= alu_result_E;
              loadM_q     <= 32'h0;
              pcM_q       <= PC_instr_E;
            end else begin
              state_q        <= BUSY;
              waitCnt_q      <= 8'd0;
              memWe_q        <= memWrite_E;
              memAddr_q      <= {alu_result_E[31:2], 2'b00};
              memWdata_q     <= wdata_d;
              memBe_q        <= be_d;
              captRegWrite_q <= regWrite_E;
              captSel_q      <= rf_wr_sel_E;
              captRd_q       <= rd_E;
              captAlu_q      <= alu_result_E;
              captPc_q       <= PC_instr_E;
              captSize_q     <= size_E;
              captUnsigned_q <= unsigned_E;
            end
          end
        end
        BUSY: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem.mem_ack) begin
            state_q     <= IDLE;
            validM_q    <= 1'b1;
            regWriteM_q <= captRegWrite_q;
            selM_q      <= captSel_q;
            rdM_q       <= captRd_q;
            aluM_q      <= captAlu_q;
            loadM_q     <= loadData_d;
            pcM_q       <= captPc_q;
          end else if (waitCnt_q == LAST_WAIT) begin
            state_q     <= IDLE;
            validM_q    <= 1'b1;
            timeoutM_q  <= 1'b1;
            regWriteM_q <= 1'b0;
            selM_q      <= captSel_q;
            rdM_q       <= captRd_q;
            aluM_q      <= captAlu_q;
            loadM_q     <= 32'h0;
            pcM_q       <= captPc_q;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = memWe_q;
  assign mem.mem_addr  = memAddr_q;
  assign mem.mem_wdata = memWdata_q;
  assign mem.mem_be    = memBe_q;

  assign stall_M      = (state_q == BUSY);
  assign valid_M      = validM_q;
  assign regWrite_M   = regWriteM_q;
  assign rf_wr_sel_M  = selM_q;
  assign rd_M         = rdM_q;
  assign alu_result_M = aluM_q;
  assign load_data_M  = loadM_q;
  assign PC_instr_M   = pcM_q;
  assign misalign_M   = misalignM_q;
  assign timeout_M    = timeoutM_q;

endmodule

// File: tb/tb_pipeline_mem_access.sv
// Scenario bench for pipeline_mem_access: expected write-back bundles are queued when an
// instruction is driven and popped when the stage reports valid_M.
module tb_pipeline_mem_access;
  localparam int MAX_WAIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_E, regWrite_E, memWrite_E, memRead2_E, unsigned_E;
  logic [1:0]  rf_wr_sel_E, size_E;
  logic [4:0]  rd_E;
  logic [31:0] alu_result_E, rs2_E, PC_instr_E;
  logic        valid_M, regWrite_M, misalign_M, timeout_M, stall_M;
  logic [1:0]  rf_wr_sel_M;
  logic [4:0]  rd_M;
  logic [31:0] alu_result_M, load_data_M, PC_instr_M;

  pipeline_mem_access_if memBus();

  pipeline_mem_access #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .valid_E(valid_E), .regWrite_E(regWrite_E), .memWrite_E(memWrite_E), .memRead2_E(memRead2_E),
    .rf_wr_sel_E(rf_wr_sel_E), .rd_E(rd_E), .size_E(size_E), .unsigned_E(unsigned_E),
    .alu_result_E(alu_result_E), .rs2_E(rs2_E), .PC_instr_E(PC_instr_E),
    .mem(memBus),
    .valid_M(valid_M), .regWrite_M(regWrite_M), .rf_wr_sel_M(rf_wr_sel_M), .rd_M(rd_M),
    .alu_result_M(alu_result_M), .load_data_M(load_data_M), .PC_instr_M(PC_instr_M),
    .misalign_M(misalign_M), .timeout_M(timeout_M), .stall_M(stall_M)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        regWrite;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] pc;
    logic        misalign;
    logic        timeout;
  } wb_t;

  wb_t sbQ[$];
  int  total = 0;
  int  bad = 0;

  function automatic wb_t observed();
    observed = {regWrite_M, rf_wr_sel_M, rd_M, alu_result_M, load_data_M, PC_instr_M, misalign_M, timeout_M};
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                            input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[int'(off) * 8 +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   modelLoad = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   modelLoad = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: modelLoad = rdata;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    valid_E = 0; regWrite_E = 0; memWrite_E = 0; memRead2_E = 0; unsigned_E = 0;
    rf_wr_sel_E = 0; size_E = 0; rd_E = 0; alu_result_E = 0; rs2_E = 0; PC_instr_E = 0;
  endtask

  task automatic popExpected(output wb_t e, output bit ok);
    ok = (sbQ.size() != 0);
    e  = '0;
    if (ok) e = sbQ.pop_front();
  endtask

  // Drives one load (wr=0) or store (wr=1) and queues what write-back must report for it.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] rdata,
                               input bit expTimeout, input bit doPush);
    wb_t  e;
    logic mis;
    valid_E = 1; memWrite_E = wr; memRead2_E = !wr; regWrite_E = !wr; rf_wr_sel_E = 2'b10;
    rd_E = rd; size_E = size; unsigned_E = uns; alu_result_E = addr; rs2_E = rs2; PC_instr_E = pc;
    memBus.mem_rdata = rdata;
    mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    e.regWrite = !wr && !mis && !expTimeout;
    e.sel      = 2'b10;
    e.rd       = rd;
    e.alu      = addr;
    e.pc       = pc;
    e.load     = (wr || mis || expTimeout) ? 32'h0 : modelLoad(size, uns, addr[1:0], rdata);
    e.misalign = mis;
    e.timeout  = expTimeout && !mis;
    if (doPush) sbQ.push_back(e);
  endtask

  // Plays the memory: acks on BUSY cycle ackCycle (0 = never), counts stall cycles, watches bus stability.
  task automatic serveAck(input int ackCycle, output int busyCycles, output bit busStable);
    logic [68:0] snap;
    busyCycles = 0;
    busStable  = 1;
    snap = {memBus.mem_addr, memBus.mem_wdata, memBus.mem_be, memBus.mem_we};
    while (stall_M === 1'b1 && busyCycles < 20) begin
      busyCycles++;
      if ({memBus.mem_addr, memBus.mem_wdata, memBus.mem_be, memBus.mem_we} !== snap) busStable = 0;
      memBus.mem_ack = (busyCycles == ackCycle);
      step();
    end
    memBus.mem_ack = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    clearInputs();
    valid_E = 1; regWrite_E = 1; rd_E = 5; alu_result_E = 32'h1234;
    memBus.mem_ack = 1; memBus.mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    total++;
    if ({valid_M, stall_M, memBus.mem_req} !== 3'b000)
      begin bad++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {valid_M, stall_M, memBus.mem_req}); end
    total++;
    if (observed() !== wb_t'(0))
      begin bad++; $display("[TB] FAIL reset_wb got=%h exp=0", observed()); end
    total++;
    if ({memBus.mem_we, memBus.mem_addr, memBus.mem_wdata, memBus.mem_be} !== 69'h0)
      begin bad++; $display("[TB] FAIL reset_bus got=%h exp=0", {memBus.mem_we, memBus.mem_addr, memBus.mem_wdata, memBus.mem_be}); end
    RST = 0;
    memBus.mem_ack = 0;
    clearInputs();
  endtask

  task automatic test_alu();
    wb_t e, o;
    bit  ok;
    clearInputs();
    valid_E = 1; regWrite_E = 1; rf_wr_sel_E = 2'b01; rd_E = 5; alu_result_E = 32'h1234;
    PC_instr_E = 32'h40; size_E = 2'b11;
    sbQ.push_back({1'b1, 2'b01, 5'd5, 32'h1234, 32'h0, 32'h40, 1'b0, 1'b0});
    step();
    clearInputs();
    total++;
    if ({valid_M, stall_M} !== 2'b10)
      begin bad++; $display("[TB] FAIL alu_valid got=%b exp=10", {valid_M, stall_M}); end
    popExpected(e, ok);
    o = observed();
    total++;
    if (!ok || o !== e) begin bad++; $display("[TB] FAIL alu_wb got=%h exp=%h queued=%0d", o, e, ok); end
    step();
    total++;
    if ({valid_M, rd_M, alu_result_M} !== {1'b0, 5'd5, 32'h1234})
      begin bad++; $display("[TB] FAIL alu_pulse_hold got=%h exp=%h", {valid_M, rd_M, alu_result_M}, {1'b0, 5'd5, 32'h1234}); end
  endtask

  task automatic test_load_byte();
    wb_t e, o;
    bit  ok, stable;
    int  busy;
    for (int u = 0; u < 2; u++) begin
      applyStimulus(1'b0, 2'b00, u[0], 32'h103, 32'h0, 5'd7, 32'h44, 32'h80FF_FFFF, 0, 1);
      step();
      // Garbage ALU op offered while BUSY must not be taken.
      clearInputs();
      valid_E = 1; regWrite_E = 1; rd_E = 5'd31; alu_result_E = 32'hDEAD;
      total++;
      if ({memBus.mem_req, memBus.mem_we, memBus.mem_addr, memBus.mem_be} !== {1'b1, 1'b0, 32'h100, 4'b1000})
        begin bad++; $display("[TB] FAIL lb_bus got=%h exp=%h", {memBus.mem_req, memBus.mem_we, memBus.mem_addr, memBus.mem_be}, {1'b1, 1'b0, 32'h100, 4'b1000}); end
      serveAck(3, busy, stable);
      clearInputs();
      total++;
      if (busy != 3 || !stable) begin bad++; $display("[TB] FAIL lb_stall got=%0d/%0d exp=3/1", busy, stable); end
      total++;
      if (load_data_M !== (u ? 32'h0000_0080 : 32'hFFFF_FF80))
        begin bad++; $display("[TB] FAIL lb_data got=%h exp=%h", load_data_M, (u ? 32'h0000_0080 : 32'hFFFF_FF80)); end
      popExpected(e, ok);
      o = observed();
      total++;
      if (!ok || valid_M !== 1'b1 || o !== e)
        begin bad++; $display("[TB] FAIL lb_wb got=%h v=%b exp=%h", o, valid_M, e); end
      step();
      total++;
      if (valid_M !== 1'b0) begin bad++; $display("[TB] FAIL lb_pulse got=%b exp=0", valid_M); end
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz[5]   = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    logic        un[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad[5]   = '{32'h102, 32'h102, 32'h100, 32'h104, 32'h101};
    logic [31:0] rdat[5] = '{32'h8001_1234, 32'h8001_1234, 32'h8001_7FFF, 32'h1234_5678, 32'h0000_7F00};
    wb_t e, o;
    bit  ok, stable;
    int  busy;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, sz[i], un[i], ad[i], 32'h0, 5'(i + 1), 32'h100 + 32'(i * 4), rdat[i], 0, 1);
      step();
      clearInputs();
      serveAck(1, busy, stable);
      popExpected(e, ok);
      o = observed();
      total++;
      if (!ok || busy != 1 || valid_M !== 1'b1 || o !== e)
        begin bad++; $display("[TB] FAIL load_%0d got=%h busy=%0d v=%b exp=%h", i, o, busy, valid_M, e); end
    end
  endtask

  task automatic test_store();
    logic [1:0]  sz[3]  = '{2'b01, 2'b00, 2'b10};
    logic [31:0] ad[3]  = '{32'h202, 32'h101, 32'h208};
    logic [31:0] dat[3] = '{32'hAABB_CCDD, 32'h1234_565A, 32'hCAFE_F00D};
    logic [3:0]  ebe[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ewd[3] = '{32'hCCDD_CCDD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    wb_t e, o;
    bit  ok, stable;
    int  busy;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, sz[i], 1'b0, ad[i], dat[i], 5'd3, 32'h80, 32'h0, 0, 1);
      step();
      clearInputs();
      total++;
      if ({memBus.mem_we, memBus.mem_be, memBus.mem_wdata, memBus.mem_addr} !== {1'b1, ebe[i], ewd[i], ad[i] & 32'hFFFF_FFFC})
        begin bad++; $display("[TB] FAIL store_bus_%0d got=%h exp=%h", i, {memBus.mem_we, memBus.mem_be, memBus.mem_wdata, memBus.mem_addr}, {1'b1, ebe[i], ewd[i], ad[i] & 32'hFFFF_FFFC}); end
      serveAck(2, busy, stable);
      popExpected(e, ok);
      o = observed();
      total++;
      if (!ok || !stable || {valid_M, regWrite_M} !== 2'b10 || o !== e)
        begin bad++; $display("[TB] FAIL store_wb_%0d got=%h v=%b stable=%0d exp=%h", i, o, valid_M, stable, e); end
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  sz[4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic        wr[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad[4] = '{32'h101, 32'h103, 32'h102, 32'h100};
    wb_t e, o;
    bit  ok;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(wr[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA, 5'd9, 32'hC0, 32'h0, 0, 1);
      step();
      clearInputs();
      total++;
      if ({memBus.mem_req, stall_M, valid_M, misalign_M, regWrite_M} !== 5'b00110)
        begin bad++; $display("[TB] FAIL misalign_ctrl_%0d got=%b exp=00110", i, {memBus.mem_req, stall_M, valid_M, misalign_M, regWrite_M}); end
      popExpected(e, ok);
      o = observed();
      total++;
      if (!ok || o !== e) begin bad++; $display("[TB] FAIL misalign_wb_%0d got=%h exp=%h", i, o, e); end
      step();
      total++;
      if ({valid_M, misalign_M, memBus.mem_req} !== 3'b000)
        begin bad++; $display("[TB] FAIL misalign_pulse_%0d got=%b exp=000", i, {valid_M, misalign_M, memBus.mem_req}); end
    end
  endtask

  task automatic test_timeout();
    wb_t e, o;
    bit  ok, stable;
    int  busy;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd9, 32'h50, 32'h1111_2222, 1, 1);
    step();
    clearInputs();
    serveAck(0, busy, stable);
    total++;
    if (busy != MAX_WAIT || {valid_M, timeout_M, stall_M, memBus.mem_req, regWrite_M} !== 5'b11000)
      begin bad++; $display("[TB] FAIL timeout_ctrl got=%0d/%b exp=%0d/11000", busy, {valid_M, timeout_M, stall_M, memBus.mem_req, regWrite_M}, MAX_WAIT); end
    popExpected(e, ok);
    o = observed();
    total++;
    if (!ok || o !== e) begin bad++; $display("[TB] FAIL timeout_wb got=%h exp=%h", o, e); end
    step();
    total++;
    if ({valid_M, timeout_M} !== 2'b00) begin bad++; $display("[TB] FAIL timeout_pulse got=%b exp=00", {valid_M, timeout_M}); end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 5'd9, 32'h54, 32'h3333_4444, 0, 1);
    step();
    clearInputs();
    serveAck(MAX_WAIT, busy, stable);
    popExpected(e, ok);
    o = observed();
    total++;
    if (!ok || busy != MAX_WAIT || {valid_M, timeout_M} !== 2'b10 || o !== e)
      begin bad++; $display("[TB] FAIL late_ack got=%h busy=%0d v=%b exp=%h", o, busy, valid_M, e); end
  endtask

  task automatic test_idle_ack();
    clearInputs();
    memBus.mem_ack = 1;
    step(); step();
    total++;
    if ({valid_M, stall_M, memBus.mem_req} !== 3'b000)
      begin bad++; $display("[TB] FAIL idle_ack got=%b exp=000", {valid_M, stall_M, memBus.mem_req}); end
    memBus.mem_ack = 0;
  endtask

  task automatic test_back_to_back();
    wb_t e, o;
    bit  ok, stable;
    int  busy;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd10, 32'h200, 32'hA5A5_0001, 0, 1);
    step();
    clearInputs();
    serveAck(1, busy, stable);
    popExpected(e, ok);
    o = observed();
    total++;
    if (!ok || valid_M !== 1'b1 || o !== e) begin bad++; $display("[TB] FAIL b2b_first got=%h v=%b exp=%h", o, valid_M, e); end
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h406, 32'h0, 5'd11, 32'h204, 32'hBEEF_0002, 0, 1);
    step();
    clearInputs();
    total++;
    if ({stall_M, valid_M, memBus.mem_addr, memBus.mem_be} !== {1'b1, 1'b0, 32'h404, 4'b1100})
      begin bad++; $display("[TB] FAIL b2b_accept got=%h exp=%h", {stall_M, valid_M, memBus.mem_addr, memBus.mem_be}, {1'b1, 1'b0, 32'h404, 4'b1100}); end
    serveAck(2, busy, stable);
    popExpected(e, ok);
    o = observed();
    total++;
    if (!ok || valid_M !== 1'b1 || o !== e) begin bad++; $display("[TB] FAIL b2b_second got=%h v=%b exp=%h", o, valid_M, e); end
  endtask

  task automatic test_reset_busy();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd4, 32'h60, 32'hDEAD_BEEF, 0, 0);
    step();
    clearInputs();
    step();
    total++;
    if (stall_M !== 1'b1) begin bad++; $display("[TB] FAIL rstbusy_busy got=%b exp=1", stall_M); end
    RST = 1;
    step();
    RST = 0;
    memBus.mem_ack = 1;
    step();
    memBus.mem_ack = 0;
    total++;
    if ({valid_M, stall_M, memBus.mem_req} !== 3'b000 || observed() !== wb_t'(0))
      begin bad++; $display("[TB] FAIL rstbusy_out got=%b/%h exp=000/0", {valid_M, stall_M, memBus.mem_req}, observed()); end
    total++;
    if ({memBus.mem_we, memBus.mem_addr, memBus.mem_wdata, memBus.mem_be} !== 69'h0)
      begin bad++; $display("[TB] FAIL rstbusy_bus got=%h exp=0", {memBus.mem_we, memBus.mem_addr, memBus.mem_wdata, memBus.mem_be}); end
    step();
    total++;
    if (valid_M !== 1'b0) begin bad++; $display("[TB] FAIL rstbusy_novalid got=%b exp=0", valid_M); end
  endtask

  initial begin
    clearInputs();
    RST = 1;
    memBus.mem_ack = 0;
    memBus.mem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_load_byte();
    test_loads();
    test_store();
    test_misalign();
    test_timeout();
    test_idle_ack();
    test_back_to_back();
    test_reset_busy();
    total++;
    if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sbQ.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
